// File: rtl/map_frame_sched.sv
// map_frame_sched: frame-level scheduler for a 4-state max-log-MAP decoder.
//
// Trellis branches, listed as from->to with the decoded bit:
//   1->1 (0), 1->2 (1), 2->3 (0), 2->4 (1), 3->1 (0), 3->2 (1), 4->3 (0), 4->4 (1)
//
// Operation: one frame of 2-bit soft symbols is buffered (LOAD). A forward
// alpha recursion then runs, one trellis step per cycle, and stores every
// alpha vector (FWD). A backward recursion follows, one step per cycle with k
// descending, and produces beta and a hard decision per step (BWD). The
// decisions are then streamed out in natural order (OUT).
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   s_valid    symbol valid           s_ready  scheduler accepts a symbol
//   s_y[1:0]   soft symbol
//   m_valid    decision valid         m_ready  sink accepts a decision
//   m_bit      decoded bit            m_last   last decision of the frame
//   busy       high in FWD, BWD and OUT
//   dbg_state  current FSM state (LOAD=0, FWD=1, BWD=2, OUT=3)
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. A valid output is held, together with its data, until it is
// accepted. Ready never depends on the valid of the same channel.

module map_frame_sched #(
    parameter int FRAME_LEN = 16,
    parameter int MW        = 8,
    parameter bit TERM      = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [1:0] s_y,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_bit,
    output logic       m_last,
    output logic       busy,
    output logic [1:0] dbg_state
);

    localparam int KW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int SW = MW + 2;
    localparam logic [KW-1:0] K_LAST = KW'(FRAME_LEN - 1);

    typedef logic signed [MW-1:0] met_t;
    typedef logic signed [SW-1:0] sum_t;
    typedef enum logic [1:0] {LOAD = 2'd0, FWD = 2'd1, BWD = 2'd2, OUT = 2'd3} state_t;

    localparam met_t NEG    = met_t'(-(2 ** (MW - 2)));
    localparam sum_t SAT_HI = sum_t'(2 ** (MW - 1) - 1);
    localparam sum_t SAT_LO = sum_t'(-(2 ** (MW - 1)));

    function automatic sum_t ext(input met_t v);
        return sum_t'(v);
    endfunction

    function automatic sum_t max2(input sum_t x, input sum_t z);
        return (x > z) ? x : z;
    endfunction

    function automatic met_t sat(input sum_t v);
        met_t r;
        if (v > SAT_HI)      r = met_t'(SAT_HI);
        else if (v < SAT_LO) r = met_t'(SAT_LO);
        else                 r = met_t'(v);
        return r;
    endfunction

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;

    logic [1:0]      sym_mem   [FRAME_LEN];
    met_t            alpha_mem [FRAME_LEN][4];
    logic [FRAME_LEN-1:0] dec_mem;

    met_t            alpha_q [4];
    met_t            beta_q  [4];
    met_t            alpha_d [4];
    met_t            beta_d  [4];
    met_t            am      [4];
    sum_t            ra      [4];
    sum_t            rb      [4];
    logic [1:0]      y;
    sum_t            ga, gb, l0, l1;
    logic            s_acc, m_acc;

    // ---------------- outputs ----------------
    assign s_ready   = rst_n && (state_q == LOAD);
    assign m_valid   = rst_n && (state_q == OUT);
    assign busy      = rst_n && (state_q != LOAD);
    assign m_bit     = m_valid && dec_mem[k_q];
    assign m_last    = m_valid && (k_q == K_LAST);
    assign dbg_state = state_q;

    assign s_acc = s_valid && s_ready;
    assign m_acc = m_valid && m_ready;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            LOAD: if (s_acc) begin
                if (k_q == K_LAST) begin
                    state_d = FWD;
                    k_d     = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            FWD: begin
                if (k_q == K_LAST) begin
                    state_d = BWD;       // backward pass starts at k = N-1
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            BWD: begin
                if (k_q == '0) begin
                    state_d = OUT;
                end else begin
                    k_d = k_q - KW'(1);
                end
            end
            OUT: if (m_acc) begin
                if (k_q == K_LAST) begin
                    state_d = LOAD;
                    k_d     = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: begin
                state_d = LOAD;
                k_d     = '0;
            end
        endcase
    end

    // ---------------- trellis datapath ----------------
    // Branch metrics: a = y1+y0 and b = y1-y0; each branch uses +/-a or +/-b.
    always_comb begin
        y  = sym_mem[k_q];
        ga = sum_t'({1'b0, y[1]}) + sum_t'({1'b0, y[0]});
        gb = sum_t'({1'b0, y[1]}) - sum_t'({1'b0, y[0]});
        am = alpha_mem[k_q];

        // forward: predecessors of 1 and 2 are {1,3}; of 3 and 4 are {2,4}
        ra[0] = max2(ext(alpha_q[0]) - ga, ext(alpha_q[2]) + ga);
        ra[1] = max2(ext(alpha_q[0]) + ga, ext(alpha_q[2]) - ga);
        ra[2] = max2(ext(alpha_q[1]) + gb, ext(alpha_q[3]) - gb);
        ra[3] = max2(ext(alpha_q[1]) - gb, ext(alpha_q[3]) + gb);

        // backward: successors of 1 and 3 are {1,2}; of 2 and 4 are {3,4}
        rb[0] = max2(ext(beta_q[0]) - ga, ext(beta_q[1]) + ga);
        rb[1] = max2(ext(beta_q[2]) + gb, ext(beta_q[3]) - gb);
        rb[2] = max2(ext(beta_q[0]) + ga, ext(beta_q[1]) - ga);
        rb[3] = max2(ext(beta_q[2]) - gb, ext(beta_q[3]) + gb);

        // bit-0 branches 11,23,31,43 and bit-1 branches 12,24,32,44
        l0 = max2(max2(ext(am[0]) - ga + ext(beta_q[0]), ext(am[1]) + gb + ext(beta_q[2])),
                  max2(ext(am[2]) + ga + ext(beta_q[0]), ext(am[3]) - gb + ext(beta_q[2])));
        l1 = max2(max2(ext(am[0]) + ga + ext(beta_q[1]), ext(am[1]) - gb + ext(beta_q[3])),
                  max2(ext(am[2]) - ga + ext(beta_q[1]), ext(am[3]) + gb + ext(beta_q[3])));

        // normalise to state 1, then saturate back to MW bits
        for (int i = 0; i < 4; i++) begin
            alpha_d[i] = sat(ra[i] - ra[0]);
            beta_d[i]  = sat(rb[i] - rb[0]);
        end
    end

    // Memories and recursion registers carry no reset; every pass
    // reinitialises what it reads before using it.
    always_ff @(posedge clk) begin
        if (s_acc) begin
            sym_mem[k_q] <= s_y;
        end
        case (state_q)
            LOAD: begin
                alpha_q[0] <= '0;
                alpha_q[1] <= NEG;
                alpha_q[2] <= NEG;
                alpha_q[3] <= NEG;
            end
            FWD: begin
                alpha_mem[k_q] <= alpha_q;
                alpha_q        <= alpha_d;
                beta_q[0]      <= '0;
                beta_q[1]      <= TERM ? NEG : '0;
                beta_q[2]      <= TERM ? NEG : '0;
                beta_q[3]      <= TERM ? NEG : '0;
            end
            BWD: begin
                dec_mem[k_q] <= (l1 >= l0);
                beta_q       <= beta_d;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_map_frame_sched.sv
`timescale 1ns/1ps
module tb_map_frame_sched;

    localparam int N   = 16;
    localparam int MWB = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // main instance: FRAME_LEN=16, TERM=1
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [1:0] s_y = 2'b00;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic       m_bit, m_last, busy;
    logic [1:0] dbg_state;

    // small instances: FRAME_LEN=1 TERM=0, and FRAME_LEN=2 TERM=1
    logic       a_valid = 1'b0, a_ready, a_mvalid, a_bit, a_last, a_busy;
    logic       a_mready = 1'b1;
    logic [1:0] a_y = 2'b00, a_dbg;
    logic       b_valid = 1'b0, b_ready, b_mvalid, b_bit, b_last, b_busy;
    logic       b_mready = 1'b1;
    logic [1:0] b_y = 2'b00, b_dbg;

    map_frame_sched #(.FRAME_LEN(N), .MW(MWB), .TERM(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_y(s_y),
        .m_valid(m_valid), .m_ready(m_ready), .m_bit(m_bit), .m_last(m_last),
        .busy(busy), .dbg_state(dbg_state)
    );

    map_frame_sched #(.FRAME_LEN(1), .MW(MWB), .TERM(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_valid(a_valid), .s_ready(a_ready), .s_y(a_y),
        .m_valid(a_mvalid), .m_ready(a_mready), .m_bit(a_bit), .m_last(a_last),
        .busy(a_busy), .dbg_state(a_dbg)
    );

    map_frame_sched #(.FRAME_LEN(2), .MW(MWB), .TERM(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_valid(b_valid), .s_ready(b_ready), .s_y(b_y),
        .m_valid(b_mvalid), .m_ready(b_mready), .m_bit(b_bit), .m_last(b_last),
        .busy(b_busy), .dbg_state(b_dbg)
    );

    // ---------------- bookkeeping ----------------
    int         checks   = 0;
    int         failures = 0;
    logic [1:0] exp_q[$];          // {last, bit}
    bit         ref_out[$];
    logic [1:0] frm[N];
    int         rdy_mode    = 0;   // 0 random, 1 toggle, 2 always ready
    int         hs_cnt      = 0;
    bit         lat_pending = 1'b0;
    int         acc_cyc     = 0;
    bit         prev_stall  = 1'b0;
    logic [1:0] e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Branch index b: 0=1->1 1=1->2 2=2->3 3=2->4 4=3->1 5=3->2 6=4->3 7=4->4
    // from = b>>1, to = b&3, decoded bit = b&1
    function automatic int gval(input int b, input int y1, input int y0);
        case (b)
            0, 5:    return -(y1 + y0);
            1, 4:    return y1 + y0;
            2, 7:    return y1 - y0;
            default: return y0 - y1;
        endcase
    endfunction

    function automatic int satv(input int v);
        int hi, lo;
        hi = (1 << (MWB - 1)) - 1;
        lo = -(1 << (MWB - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic void ref_model(input int n, input bit term);
        int al[N][4];
        int be[4];
        int nv[4];
        int neg, v, y1, y0, l0, l1, base;
        bit dec[N];
        neg = -(1 << (MWB - 2));
        al[0][0] = 0;
        for (int s = 1; s < 4; s++) al[0][s] = neg;
        for (int k = 0; k < n - 1; k++) begin
            y1 = int'(frm[k][1]);
            y0 = int'(frm[k][0]);
            for (int s = 0; s < 4; s++) nv[s] = -1000000;
            for (int b = 0; b < 8; b++) begin
                v = al[k][b >> 1] + gval(b, y1, y0);
                if (v > nv[b & 3]) nv[b & 3] = v;
            end
            base = nv[0];
            for (int s = 0; s < 4; s++) al[k + 1][s] = satv(nv[s] - base);
        end
        be[0] = 0;
        for (int s = 1; s < 4; s++) be[s] = term ? neg : 0;
        for (int k = n - 1; k >= 0; k--) begin
            y1 = int'(frm[k][1]);
            y0 = int'(frm[k][0]);
            l0 = -1000000;
            l1 = -1000000;
            for (int s = 0; s < 4; s++) nv[s] = -1000000;
            for (int b = 0; b < 8; b++) begin
                v = al[k][b >> 1] + gval(b, y1, y0) + be[b & 3];
                if ((b & 1) == 1) begin
                    if (v > l1) l1 = v;
                end else begin
                    if (v > l0) l0 = v;
                end
                v = gval(b, y1, y0) + be[b & 3];
                if (v > nv[b >> 1]) nv[b >> 1] = v;
            end
            dec[k] = (l1 >= l0);
            base = nv[0];
            for (int s = 0; s < 4; s++) be[s] = satv(nv[s] - base);
        end
        ref_out.delete();
        for (int k = 0; k < n; k++) ref_out.push_back(dec[k]);
    endfunction

    // ---------------- sink ready driver ----------------
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_ready = ($urandom_range(0, 3) != 0);
            1:       m_ready = ~m_ready;
            default: m_ready = 1'b1;
        endcase
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) chk("s_ready_while_busy", s_ready, 0);
            if (prev_stall) chk("valid_held", m_valid, 1);
            if (m_valid && lat_pending) begin
                chk("latency", cyc - acc_cyc, 2 * N + 1);
                lat_pending = 1'b0;
            end
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", exp_q.size(), 1);
                end else begin
                    // checked every valid cycle: output must match the
                    // pending expectation while stalled as well
                    chk("out_last_bit", {m_last, m_bit}, exp_q[0]);
                    if (m_ready) begin
                        e = exp_q.pop_front();
                        hs_cnt++;
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    // Entered and left at posedge+1.
    task automatic send_frame(input int pat, input bit reuse, input bit hold, input int gap_max);
        bit got;
        int idle;
        if (!reuse) begin
            for (int i = 0; i < N; i++) begin
                case (pat)
                    0:       frm[i] = 2'($urandom_range(0, 3));
                    1:       frm[i] = 2'b11;
                    2:       frm[i] = 2'b00;
                    default: frm[i] = (i % 2 == 1) ? 2'b00 : 2'b11;
                endcase
            end
        end
        ref_model(N, 1'b1);
        for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), ref_out[i]});
        for (int i = 0; i < N; i++) begin
            idle = $urandom_range(0, gap_max);
            repeat (idle) begin
                s_valid = 1'b0;
                s_y     = 2'($urandom_range(0, 3));
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_y     = frm[i];
            got = 1'b0;
            for (int w = 0; w < 200 && !got; w++) begin
                @(negedge clk);
                got = s_ready;
            end
            if (!got) chk("accept_timeout", got, 1);
            if (i == N - 1) begin
                acc_cyc     = cyc;
                lat_pending = 1'b1;
            end
            @(posedge clk); #1;
        end
        s_valid = hold;
        s_y     = 2'($urandom_range(0, 3));
    endtask

    // Returns at posedge+1 right after the last decision was accepted.
    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 3000) begin
            @(posedge clk);
            w++;
        end
        chk("drain_left", exp_q.size(), 0);
        exp_q.delete();
        #1;
    endtask

    task automatic run_a(input logic [1:0] sym, input logic exp_bit);
        a_valid = 1'b1;
        a_y     = sym;
        @(negedge clk);
        chk("a_ready", a_ready, 1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("a_busy", a_busy, 1);
            chk("a_mvalid", a_mvalid, (c == 3));
        end
        chk("a_bit", a_bit, exp_bit);
        chk("a_last", a_last, 1);
        @(negedge clk);
        chk("a_busy_after", a_busy, 0);
        chk("a_ready_after", a_ready, 1);
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        // reset held for two cycles
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_s_ready", s_ready, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_m_bit_last", {m_bit, m_last}, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_s_ready", s_ready, 1);
        chk("post_rst_a_ready", a_ready, 1);
        @(posedge clk); #1;

        // random frames with random gaps and random backpressure
        for (int f = 0; f < 3; f++) begin
            send_frame(0, 1'b0, 1'b0, 2);
            drain();
        end

        // boundary symbol patterns, sink always ready
        rdy_mode = 2;
        for (int p = 1; p <= 3; p++) begin
            send_frame(p, 1'b0, 1'b0, 0);
            drain();
        end

        // ready toggling 1-0-1 in OUT
        rdy_mode = 1;
        hs_cnt   = 0;
        send_frame(0, 1'b0, 1'b0, 0);
        drain();
        chk("handshake_count", hs_cnt, N);
        @(negedge clk);
        chk("ready_after_toggle_frame", s_ready, 1);
        @(posedge clk); #1;

        // s_valid held high while busy, then a normal frame
        rdy_mode = 0;
        send_frame(0, 1'b0, 1'b1, 1);
        drain();
        send_frame(0, 1'b0, 1'b0, 1);
        drain();

        // reset during BWD, then the same frame again
        send_frame(0, 1'b0, 1'b0, 1);
        repeat (N + 4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        lat_pending = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_s_ready", s_ready, 1);
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_busy", busy, 0);
        @(posedge clk); #1;
        send_frame(0, 1'b1, 1'b0, 1);
        drain();

        // a few more random frames
        for (int f = 0; f < 3; f++) begin
            send_frame(0, 1'b0, 1'b0, 2);
            drain();
        end

        // FRAME_LEN=1, TERM=0: y=11 -> 1, y=00 -> 1 (tie)
        run_a(2'b11, 1'b1);
        run_a(2'b00, 1'b1);

        // FRAME_LEN=2, TERM=1: 11,11 -> 0,0
        for (int i = 0; i < 2; i++) begin
            b_valid = 1'b1;
            b_y     = 2'b11;
            @(negedge clk);
            chk("b_ready", b_ready, 1);
            @(posedge clk); #1;
        end
        b_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("b_busy", b_busy, 1);
            chk("b_mvalid_early", b_mvalid, 0);
        end
        @(negedge clk);
        chk("b_mvalid0", b_mvalid, 1);
        chk("b_dec0", {b_last, b_bit}, 2'b00);
        @(negedge clk);
        chk("b_mvalid1", b_mvalid, 1);
        chk("b_dec1", {b_last, b_bit}, 2'b10);
        @(negedge clk);
        chk("b_idle", b_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #400000;
        failures++;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
